// File: rtl/dht_pkg.sv
// Shared definitions for the DHT22 reader: FSM states, frame geometry, timing
// conversion and checksum arithmetic.
package dht_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    RELEASE,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } state_t;

  localparam int US_PER_S   = 1_000_000;
  localparam int FRAME_BITS = 40;

  function automatic int us_to_cyc(input int clk_hz, input int us);
    longint prod;
    prod = longint'(clk_hz) * longint'(us);
    return int'(prod / longint'(US_PER_S));
  endfunction

  // Sum of the four payload bytes, modulo 256 by truncation.
  function automatic logic [7:0] frame_sum(input logic [FRAME_BITS-1:0] f);
    return f[39:32] + f[31:24] + f[23:16] + f[15:8];
  endfunction

endpackage

// File: rtl/dht22_reader_if.sv
// Synchronized sensor-line view: settled level plus single-cycle edge strobes.
interface dht22_reader_if;
  logic level;
  logic rise;
  logic fall;

  modport master (output level, output rise, output fall);
  modport slave  (input  level, input  rise, input  fall);
endinterface

// File: rtl/dht_sync_edge.sv
// Two-flop synchronizer for the raw sensor pad with rise/fall detection on the
// synchronized level. Flops reset high to match the idle pulled-up line.
module dht_sync_edge (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            din,
  dht22_reader_if.master  line
);

  logic sync0;
  logic sync1;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync0 <= din;
      sync1 <= sync0;
      prev  <= sync1;
    end
  end

  assign line.level = sync1;
  assign line.rise  = sync1 & ~prev;
  assign line.fall  = ~sync1 & prev;

endmodule

// File: rtl/dht22_reader.sv
// DHT22 single-wire reader: host start pulse, sensor response handshake,
// 40-bit pulse-width decode, checksum validation and result registers.
module dht22_reader
  import dht_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int START_US   = 1100,
  parameter int TIMEOUT_US = 200,
  parameter int BIT1_US    = 50
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        start,
  input  logic        dht_in,
  output logic        dht_oe,
  output logic [15:0] RH_Value,
  output logic [15:0] Temp_Value,
  output logic        valid,
  output logic        busy,
  output logic        chk_err,
  output logic        tmo_err
);

  localparam int START_CYC = us_to_cyc(CLK_HZ, START_US);
  localparam int TMO_CYC   = us_to_cyc(CLK_HZ, TIMEOUT_US);
  localparam int BIT1_CYC  = us_to_cyc(CLK_HZ, BIT1_US);
  localparam int MAX_AB    = (START_CYC > TMO_CYC) ? START_CYC : TMO_CYC;
  localparam int CNT_MAX   = (MAX_AB > BIT1_CYC) ? MAX_AB : BIT1_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1) + 1;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LIM    = CNT_W'(TMO_CYC);
  // The phase counter reads (high cycles - 1) on the cycle the fall is seen.
  localparam logic [CNT_W-1:0] BIT1_LAST  = CNT_W'(BIT1_CYC - 1);
  localparam logic [5:0]       LAST_BIT   = 6'(FRAME_BITS - 1);

  dht22_reader_if line_bus ();

  dht_sync_edge u_sync (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .din   (dht_in),
    .line  (line_bus)
  );

  state_t                  state;
  state_t                  state_nx;
  logic [CNT_W-1:0]        cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic [5:0]              bit_cnt;
  logic                    phase_over;
  logic                    tmo_hit;
  logic                    bit_val;
  logic                    sum_ok;

  assign phase_over = (cnt >= TMO_LIM);
  assign bit_val    = (cnt >= BIT1_LAST);
  assign sum_ok     = (frame_sum(shreg) == shreg[7:0]);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    case (state)
      IDLE:      if (start) state_nx = START_LOW;
      START_LOW: if (cnt >= START_LAST) state_nx = RELEASE;
      RELEASE: begin
        if (line_bus.fall)   state_nx = RESP_LOW;
        else if (phase_over) begin state_nx = IDLE; tmo_hit = 1'b1; end
      end
      RESP_LOW: begin
        if (line_bus.rise)   state_nx = RESP_HIGH;
        else if (phase_over) begin state_nx = IDLE; tmo_hit = 1'b1; end
      end
      RESP_HIGH: begin
        if (line_bus.fall)   state_nx = BIT_LOW;
        else if (phase_over) begin state_nx = IDLE; tmo_hit = 1'b1; end
      end
      BIT_LOW: begin
        if (line_bus.rise)   state_nx = BIT_HIGH;
        else if (phase_over) begin state_nx = IDLE; tmo_hit = 1'b1; end
      end
      BIT_HIGH: begin
        if (line_bus.fall)   state_nx = (bit_cnt == LAST_BIT) ? CHECK : BIT_LOW;
        else if (phase_over) begin state_nx = IDLE; tmo_hit = 1'b1; end
      end
      CHECK:     state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Phase counter restarts on each state entry and saturates instead of wrapping.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)            cnt <= '0;
    else if (state_nx != state) cnt <= '0;
    else if (cnt != '1)         cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      RH_Value   <= '0;
      Temp_Value <= '0;
      valid      <= 1'b0;
      chk_err    <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      valid   <= 1'b0;
      chk_err <= 1'b0;
      tmo_err <= tmo_hit;
      if (state == IDLE && start) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end
      if (state == BIT_HIGH && line_bus.fall) begin
        shreg   <= {shreg[FRAME_BITS-2:0], bit_val};
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (state == CHECK) begin
        if (sum_ok) begin
          RH_Value   <= shreg[39:24];
          Temp_Value <= shreg[23:8];
          valid      <= 1'b1;
        end else begin
          chk_err    <= 1'b1;
        end
      end
    end
  end

  assign dht_oe = (state == START_LOW);
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_dht22_reader.sv
// Bench for dht22_reader: behavioural DHT22 sensor on the pad, frame-level
// reference model for decode/checksum, and pulse monitors on the status outputs.
module tb_dht22_reader;

  localparam int CLK_HZ     = 1_000_000;
  localparam int START_US   = 1100;
  localparam int TIMEOUT_US = 200;
  localparam int BIT1_US    = 50;
  localparam int START_CYC  = int'(longint'(START_US) * CLK_HZ / 1_000_000);
  localparam int TMO_CYC    = int'(longint'(TIMEOUT_US) * CLK_HZ / 1_000_000);
  localparam int BIT1_CYC   = int'(longint'(BIT1_US) * CLK_HZ / 1_000_000);
  localparam int LOW_CYC    = 50;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        dht_in;
  logic        dht_oe;
  logic [15:0] rh;
  logic [15:0] temp;
  logic        valid;
  logic        busy;
  logic        chk_err;
  logic        tmo_err;

  int n_tests;
  int n_fail;
  int n_valid   = 0;
  int n_chk     = 0;
  int n_tmo     = 0;
  int n_overlap = 0;
  logic [15:0] seen_rh = '0;
  logic [15:0] seen_t  = '0;
  logic [15:0] exp_rh;
  logic [15:0] exp_t;

  dht22_reader #(
    .CLK_HZ     (CLK_HZ),
    .START_US   (START_US),
    .TIMEOUT_US (TIMEOUT_US),
    .BIT1_US    (BIT1_US)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .start      (start),
    .dht_in     (dht_in),
    .dht_oe     (dht_oe),
    .RH_Value   (rh),
    .Temp_Value (temp),
    .valid      (valid),
    .busy       (busy),
    .chk_err    (chk_err),
    .tmo_err    (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        n_valid++;
        seen_rh = rh;
        seen_t  = temp;
      end
      if (chk_err) n_chk++;
      if (tmo_err) n_tmo++;
      if ($countones({valid, chk_err, tmo_err}) > 1) n_overlap++;
    end
  end

  // Reference: a frame is accepted when the byte sum mod 256 equals byte4.
  function automatic bit model_frame(input logic [39:0] f);
    int sum;
    sum = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    if ((sum % 256) == int'(f[7:0])) begin
      exp_rh = f[39:24];
      exp_t  = f[23:8];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [39:0] decode(input logic [39:0] f, input int hi0, input int hi1);
    logic [39:0] d;
    for (int i = 0; i < 40; i++) d[i] = ((f[i] ? hi1 : hi0) >= BIT1_CYC);
    return d;
  endfunction

  function automatic logic [39:0] make_frame(input bit corrupt);
    logic [7:0] b [4];
    logic [7:0] ck;
    int sum;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      sum += int'(b[i]);
    end
    ck = 8'(sum % 256);
    if (corrupt) ck = ck ^ (8'd1 << $urandom_range(7, 0));
    return {b[0], b[1], b[2], b[3], ck};
  endfunction

  // Sensor model. inj_kind 1 pulses start at the low phase of bit inj_bit,
  // inj_kind 2 asserts reset there and returns with reset held.
  task automatic drive_frame(input logic [39:0] f, input int hi0, input int hi1,
                             input int inj_bit, input int inj_kind,
                             output int oe_n, output bit ok);
    int guard;
    ok = 1'b1;
    oe_n = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (dht_oe === 1'b1 && oe_n < START_CYC + 50) begin
      oe_n++;
      @(negedge clk);
    end
    if (dht_oe !== 1'b0 || oe_n == 0) begin
      ok = 1'b0;
      return;
    end
    repeat (20) @(negedge clk);
    dht_in = 1'b0; repeat (80) @(negedge clk);
    dht_in = 1'b1; repeat (80) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      dht_in = 1'b0;
      if (i == inj_bit && inj_kind == 2) begin
        rst_n = 1'b0;
        return;
      end
      if (i == inj_bit && inj_kind == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (LOW_CYC - 1) @(negedge clk);
      dht_in = 1'b1;
      repeat (f[39-i] ? hi1 : hi0) @(negedge clk);
    end
    dht_in = 1'b0; repeat (LOW_CYC) @(negedge clk);
    dht_in = 1'b1;
    guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (busy !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({dht_oe, busy, valid, chk_err, tmo_err, rh, temp} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", {dht_oe, busy, valid, chk_err, tmo_err, rh, temp});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if ({dht_oe, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: got oe/busy=%b expected 00", {dht_oe, busy});
    end
  endtask

  task automatic test_good_frame();
    logic [39:0] f;
    int oe_n, v0, c0;
    bit ok, exp_ok;
    f = 40'h028C015FEE;
    v0 = n_valid; c0 = n_chk;
    exp_ok = model_frame(f);
    drive_frame(f, 26, 70, -1, 0, oe_n, ok);
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL good_handshake: got %b expected 1", ok); end
    n_tests++;
    if (oe_n !== START_CYC) begin n_fail++; $display("FAIL good_start_low: got %0d cycles expected %0d", oe_n, START_CYC); end
    n_tests++;
    if ((n_valid - v0) !== int'(exp_ok) || (n_chk - c0) !== 0) begin
      n_fail++; $display("FAIL good_pulses: got valid=%0d chk=%0d expected 1 0", n_valid - v0, n_chk - c0);
    end
    n_tests++;
    if ({rh, temp} !== {16'h028C, 16'h015F}) begin
      n_fail++; $display("FAIL good_values: got %h %h expected 028c 015f", rh, temp);
    end
    n_tests++;
    if ({seen_rh, seen_t} !== {exp_rh, exp_t}) begin
      n_fail++; $display("FAIL good_values_at_valid: got %h %h expected %h %h", seen_rh, seen_t, exp_rh, exp_t);
    end
  endtask

  task automatic test_bad_checksum();
    logic [39:0] f;
    int oe_n, v0, c0;
    bit ok, exp_ok;
    f = 40'h028C015FEF;
    v0 = n_valid; c0 = n_chk;
    exp_ok = model_frame(f);
    drive_frame(f, 26, 70, -1, 0, oe_n, ok);
    n_tests++;
    if ((n_chk - c0) !== int'(!exp_ok) || (n_valid - v0) !== 0) begin
      n_fail++; $display("FAIL bad_ck_pulses: got chk=%0d valid=%0d expected 1 0", n_chk - c0, n_valid - v0);
    end
    n_tests++;
    if ({rh, temp} !== {exp_rh, exp_t}) begin
      n_fail++; $display("FAIL bad_ck_hold: got %h %h expected %h %h", rh, temp, exp_rh, exp_t);
    end
    n_tests++;
    if (ok !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bad_ck_busy: got ok=%b busy=%b expected 1 0", ok, busy);
    end
  endtask

  task automatic test_no_response();
    int oe_n, gap, t0, v0, c0;
    t0 = n_tmo; v0 = n_valid; c0 = n_chk;
    dht_in = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    oe_n = 0;
    while (dht_oe === 1'b1 && oe_n < START_CYC + 50) begin oe_n++; @(negedge clk); end
    n_tests++;
    if (oe_n !== START_CYC) begin n_fail++; $display("FAIL nresp_start_low: got %0d expected %0d", oe_n, START_CYC); end
    gap = 0;
    while (tmo_err !== 1'b1 && gap < TMO_CYC + 50) begin gap++; @(negedge clk); end
    n_tests++;
    if (gap < TMO_CYC || gap > TMO_CYC + 2) begin
      n_fail++; $display("FAIL nresp_tmo_delay: got %0d cycles expected %0d..%0d", gap, TMO_CYC, TMO_CYC + 2);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if ((n_tmo - t0) !== 1 || (n_valid - v0) !== 0 || (n_chk - c0) !== 0) begin
      n_fail++; $display("FAIL nresp_pulses: got tmo=%0d valid=%0d chk=%0d expected 1 0 0", n_tmo - t0, n_valid - v0, n_chk - c0);
    end
    n_tests++;
    if ({busy, rh, temp} !== {1'b0, exp_rh, exp_t}) begin
      n_fail++; $display("FAIL nresp_hold: got busy=%b %h %h expected 0 %h %h", busy, rh, temp, exp_rh, exp_t);
    end
  endtask

  task automatic test_bit_threshold();
    int hi0s [3];
    int hi1s [3];
    logic [39:0] f;
    int oe_n, v0, c0;
    bit ok, exp_ok;
    hi0s = '{BIT1_CYC - 1, BIT1_CYC - 1, BIT1_CYC};
    hi1s = '{BIT1_CYC,     BIT1_CYC - 1, BIT1_CYC};
    for (int k = 0; k < 3; k++) begin
      f = make_frame(1'b0);
      v0 = n_valid; c0 = n_chk;
      exp_ok = model_frame(decode(f, hi0s[k], hi1s[k]));
      drive_frame(f, hi0s[k], hi1s[k], -1, 0, oe_n, ok);
      n_tests++;
      if (ok !== 1'b1 || (n_valid - v0) !== int'(exp_ok) || (n_chk - c0) !== int'(!exp_ok)) begin
        n_fail++; $display("FAIL threshold_%0d_pulses: got ok=%b valid=%0d chk=%0d expected 1 %0d %0d",
                           k, ok, n_valid - v0, n_chk - c0, int'(exp_ok), int'(!exp_ok));
      end
      n_tests++;
      if ({rh, temp} !== {exp_rh, exp_t}) begin
        n_fail++; $display("FAIL threshold_%0d_values: got %h %h expected %h %h", k, rh, temp, exp_rh, exp_t);
      end
    end
  endtask

  task automatic test_start_during_busy();
    logic [39:0] f;
    int oe_n, v0, oe_seen;
    bit ok, exp_ok;
    f = make_frame(1'b0);
    v0 = n_valid;
    exp_ok = model_frame(f);
    drive_frame(f, 24, 72, 10, 1, oe_n, ok);
    n_tests++;
    if (ok !== 1'b1 || (n_valid - v0) !== int'(exp_ok) || {rh, temp} !== {exp_rh, exp_t}) begin
      n_fail++; $display("FAIL busy_start_frame: got ok=%b valid=%0d %h %h expected 1 1 %h %h",
                         ok, n_valid - v0, rh, temp, exp_rh, exp_t);
    end
    oe_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (dht_oe === 1'b1 || busy === 1'b1) oe_seen++;
    end
    n_tests++;
    if (oe_seen !== 0) begin n_fail++; $display("FAIL busy_start_ignored: got %0d busy cycles expected 0", oe_seen); end
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] f;
    int oe_n, v0, e0, idle_bad;
    bit ok, exp_ok;
    e0 = n_chk + n_tmo;
    drive_frame(make_frame(1'b0), 24, 72, 20, 2, oe_n, ok);
    #1;
    n_tests++;
    if ({dht_oe, busy, valid, chk_err, tmo_err, rh, temp} !== 37'd0) begin
      n_fail++; $display("FAIL midreset_state: got %h expected 0", {dht_oe, busy, valid, chk_err, tmo_err, rh, temp});
    end
    exp_rh = '0; exp_t = '0;
    dht_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy !== 1'b0 || dht_oe !== 1'b0) idle_bad++;
    end
    n_tests++;
    if (idle_bad !== 0 || (n_chk + n_tmo) !== e0) begin
      n_fail++; $display("FAIL midreset_idle: got %0d busy cycles, %0d errors expected 0 0", idle_bad, n_chk + n_tmo - e0);
    end
    f = make_frame(1'b0);
    v0 = n_valid;
    exp_ok = model_frame(f);
    drive_frame(f, 30, 66, -1, 0, oe_n, ok);
    n_tests++;
    if (ok !== 1'b1 || (n_valid - v0) !== int'(exp_ok) || {rh, temp} !== {exp_rh, exp_t}) begin
      n_fail++; $display("FAIL midreset_next_frame: got ok=%b valid=%0d %h %h expected 1 1 %h %h",
                         ok, n_valid - v0, rh, temp, exp_rh, exp_t);
    end
  endtask

  task automatic test_random_frames();
    logic [39:0] f;
    int oe_n, v0, c0, hi0, hi1;
    bit ok, exp_ok;
    for (int k = 0; k < 3; k++) begin
      f   = make_frame($urandom_range(2, 0) == 0);
      hi0 = $urandom_range(BIT1_CYC - 1, 15);
      hi1 = $urandom_range(80, BIT1_CYC);
      v0 = n_valid; c0 = n_chk;
      exp_ok = model_frame(decode(f, hi0, hi1));
      drive_frame(f, hi0, hi1, -1, 0, oe_n, ok);
      n_tests++;
      if (ok !== 1'b1 || (n_valid - v0) !== int'(exp_ok) || (n_chk - c0) !== int'(!exp_ok)) begin
        n_fail++; $display("FAIL random_%0d_pulses: frame %h got ok=%b valid=%0d chk=%0d expected 1 %0d %0d",
                           k, f, ok, n_valid - v0, n_chk - c0, int'(exp_ok), int'(!exp_ok));
      end
      n_tests++;
      if ({rh, temp} !== {exp_rh, exp_t}) begin
        n_fail++; $display("FAIL random_%0d_values: got %h %h expected %h %h", k, rh, temp, exp_rh, exp_t);
      end
    end
    n_tests++;
    if (n_overlap !== 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", n_overlap); end
  endtask

  initial begin
    #(20_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    start   = 1'b0;
    dht_in  = 1'b1;
    rst_n   = 1'b0;
    exp_rh  = '0;
    exp_t   = '0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_no_response();
    test_bit_threshold();
    test_start_during_busy();
    test_reset_mid_frame();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
